// File: rtl/bp_corr_predictor_pkg.sv
// Shared constants and counter helpers for the correlating branch predictor.
package bp_pkg;

  localparam int IDX_CONCAT = 0;
  localparam int IDX_GSHARE = 1;

  typedef logic [63:0] bp_word_t;

  function automatic bp_word_t ctr_init(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic bp_word_t ctr_next(input bp_word_t value, input logic taken, input int width);
    bp_word_t max_v;
    max_v = (64'd1 << width) - 64'd1;
    if (taken) return (value == max_v) ? value : value + 64'd1;
    else       return (value == 64'd0) ? value : value - 64'd1;
  endfunction

  function automatic bp_word_t sat_inc(input bp_word_t value, input int width);
    bp_word_t max_v;
    max_v = (64'd1 << width) - 64'd1;
    return (value == max_v) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/bp_corr_predictor_ctr_table.sv
// Saturating-counter array: combinational read, synchronous write, reset to weakly-not-taken.
module bp_ctr_table
  import bp_pkg::*;
#(
  parameter int DEPTH_W = 5,
  parameter int CTR_W   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DEPTH_W-1:0] rd_idx,
  output logic [CTR_W-1:0]   rd_ctr,
  input  logic               wr_en,
  input  logic [DEPTH_W-1:0] wr_idx,
  input  logic [CTR_W-1:0]   wr_ctr
);

  localparam int                DEPTH  = 1 << DEPTH_W;
  localparam bp_word_t          INIT_W = ctr_init(CTR_W);
  localparam logic [CTR_W-1:0]  INIT_V = INIT_W[CTR_W-1:0];

  logic [CTR_W-1:0] table_q [DEPTH];
  logic [CTR_W-1:0] table_d [DEPTH];

  assign rd_ctr = table_q[rd_idx];

  always_comb begin
    table_d = table_q;
    if (wr_en) table_d[wr_idx] = wr_ctr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= INIT_V;
    end else begin
      table_q <= table_d;
    end
  end

endmodule

// File: rtl/bp_corr_predictor.sv
// (m,n) correlating branch predictor with global history and a saturating mispredict count.
// Optional BP_STATS_EN adds a saturating count of valid lookups; otherwise lookups is tied to 0.
module bp_corr_predictor
  import bp_pkg::*;
#(
  parameter int GHR_W      = 4,
  parameter int CTR_W      = 2,
  parameter int BR_IDX_W   = 1,
  parameter int INDEX_MODE = 0,
  parameter int MISS_W     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic [BR_IDX_W-1:0] branch_id,
  input  logic                outcome,
  output logic [CTR_W-1:0]    predict,
  output logic                pred_taken,
  output logic [GHR_W-1:0]    global_history,
  output logic [MISS_W-1:0]   mismatch,
  output logic [MISS_W-1:0]   lookups
);

  localparam int DEPTH_W = (INDEX_MODE == IDX_GSHARE) ? GHR_W : BR_IDX_W + GHR_W;

  logic [GHR_W-1:0]   ghr_q, ghr_d, ghr_shift;
  logic [MISS_W-1:0]  mismatch_q, mismatch_d;
  logic [DEPTH_W-1:0] idx;
  logic [CTR_W-1:0]   wr_ctr;

  generate
    if (INDEX_MODE == IDX_GSHARE) begin : g_gshare
      logic [GHR_W-1:0] bid_ext;
      if (BR_IDX_W >= GHR_W) begin : g_trunc
        assign bid_ext = branch_id[GHR_W-1:0];
      end else begin : g_zext
        assign bid_ext = {{(GHR_W-BR_IDX_W){1'b0}}, branch_id};
      end
      assign idx = ghr_q ^ bid_ext;
    end else begin : g_concat
      assign idx = {branch_id, ghr_q};
    end

    if (GHR_W == 1) begin : g_ghr1
      assign ghr_shift = outcome;
    end else begin : g_ghrn
      assign ghr_shift = {ghr_q[GHR_W-2:0], outcome};
    end
  endgenerate

  bp_ctr_table #(
    .DEPTH_W (DEPTH_W),
    .CTR_W   (CTR_W)
  ) u_table (
    .clk    (clk),
    .reset  (reset),
    .rd_idx (idx),
    .rd_ctr (predict),
    .wr_en  (valid),
    .wr_idx (idx),
    .wr_ctr (wr_ctr)
  );

  assign pred_taken     = predict[CTR_W-1];
  assign global_history = ghr_q;
  assign mismatch       = mismatch_q;

  // Pre-update counter drives both the prediction compare and the write-back step.
  always_comb begin
    ghr_d      = ghr_q;
    mismatch_d = mismatch_q;
    wr_ctr     = CTR_W'(ctr_next(bp_word_t'(predict), outcome, CTR_W));
    if (valid) begin
      ghr_d = ghr_shift;
      if (pred_taken != outcome)
        mismatch_d = MISS_W'(sat_inc(bp_word_t'(mismatch_q), MISS_W));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q      <= '0;
      mismatch_q <= '0;
    end else begin
      ghr_q      <= ghr_d;
      mismatch_q <= mismatch_d;
    end
  end

`ifdef BP_STATS_EN
  logic [MISS_W-1:0] lookups_q, lookups_d;

  always_comb begin
    lookups_d = lookups_q;
    if (valid) lookups_d = MISS_W'(sat_inc(bp_word_t'(lookups_q), MISS_W));
  end

  always_ff @(posedge clk) begin
    if (reset) lookups_q <= '0;
    else       lookups_q <= lookups_d;
  end

  assign lookups = lookups_q;
`else
  assign lookups = '0;
`endif

endmodule

// File: tb/tb_bp_corr_predictor.sv
// Directed bench: default concat predictor plus a gshare instance with a 4-bit miss counter.
module tb_bp_corr_predictor;

  logic        clk = 1'b0;
  logic        reset;

  logic        d_valid, d_out, d_pt;
  logic [0:0]  d_bid;
  logic [1:0]  d_pred;
  logic [3:0]  d_ghr;
  logic [31:0] d_miss, d_look;

  logic        g_valid, g_out, g_pt;
  logic [3:0]  g_bid;
  logic [1:0]  g_pred;
  logic [3:0]  g_ghr;
  logic [3:0]  g_miss, g_look;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bp_corr_predictor u_def (
    .clk            (clk),
    .reset          (reset),
    .valid          (d_valid),
    .branch_id      (d_bid),
    .outcome        (d_out),
    .predict        (d_pred),
    .pred_taken     (d_pt),
    .global_history (d_ghr),
    .mismatch       (d_miss),
    .lookups        (d_look)
  );

  bp_corr_predictor #(
    .GHR_W      (4),
    .CTR_W      (2),
    .BR_IDX_W   (4),
    .INDEX_MODE (1),
    .MISS_W     (4)
  ) u_gs (
    .clk            (clk),
    .reset          (reset),
    .valid          (g_valid),
    .branch_id      (g_bid),
    .outcome        (g_out),
    .predict        (g_pred),
    .pred_taken     (g_pt),
    .global_history (g_ghr),
    .mismatch       (g_miss),
    .lookups        (g_look)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] ghr_exp  [8] = '{4'h1, 4'h3, 4'h7, 4'hf, 4'hf, 4'hf, 4'hf, 4'hf};
    logic [1:0] pred_exp [8] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
    int         miss_exp [8] = '{1, 2, 3, 4, 5, 5, 5, 5};

    // Reset held two cycles with valid asserted.
    reset = 1'b1; d_valid = 1'b1; d_bid = 1'b0; d_out = 1'b1;
    g_valid = 1'b0; g_bid = 4'd0; g_out = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_pred", d_pred, 2'b01);
    chk("rst_pt", d_pt, 1'b0);
    chk("rst_ghr", d_ghr, 4'h0);
    chk("rst_miss", d_miss, 0);
    chk("rst_look", d_look, 0);

    // Train branch 0 taken for 8 cycles.
    for (int i = 0; i < 8; i++) begin
      d_valid = 1'b1; d_bid = 1'b0; d_out = 1'b1;
      #1;
      chk("train_pred", d_pred, pred_exp[i]);
      tick();
      chk("train_ghr", d_ghr, ghr_exp[i]);
      chk("train_miss", d_miss, miss_exp[i]);
    end
    chk("train_sat", d_pred, 2'd3);
`ifdef BP_STATS_EN
    chk("train_look", d_look, 8);
`else
    chk("train_look", d_look, 0);
`endif

    // Idle cycles with toggling inputs change nothing.
    d_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      d_bid = i[0];
      d_out = ~i[0];
      tick();
    end
    chk("idle_ghr", d_ghr, 4'hf);
    chk("idle_miss", d_miss, 5);
    d_bid = 1'b0; #1;
    chk("idle_pred_b0", d_pred, 2'd3);
    d_bid = 1'b1; #1;
    chk("idle_pred_b1", d_pred, 2'd1);
`ifdef BP_STATS_EN
    chk("idle_look", d_look, 8);
`else
    chk("idle_look", d_look, 0);
`endif

    // Reset wins over a mispredicting valid in the same cycle.
    d_bid = 1'b0; d_out = 1'b0; d_valid = 1'b1; reset = 1'b1;
    #1;
    chk("mid_pt_before", d_pt, 1'b1);
    tick();
    reset = 1'b0; d_valid = 1'b0;
    #1;
    chk("mid_miss", d_miss, 0);
    chk("mid_ghr", d_ghr, 4'h0);
    chk("mid_pred", d_pred, 2'b01);
    chk("mid_look", d_look, 0);

    // Gshare: train entry 0 via branch 0, alias it through branch 3 at GHR=0011.
    g_valid = 1'b1; g_bid = 4'd0; g_out = 1'b1;
    #1; chk("gs_pred0", g_pred, 2'd1);
    tick();
    #1; chk("gs_pred1", g_pred, 2'd1);
    tick();
    chk("gs_ghr3", g_ghr, 4'h3);
    chk("gs_miss2", g_miss, 4'd2);
    g_bid = 4'd3;
    #1; chk("gs_alias_pred", g_pred, 2'd2);
    tick();
    chk("gs_ghr7", g_ghr, 4'h7);
    chk("gs_miss_hit", g_miss, 4'd2);
    g_bid = 4'd0; g_out = 1'b0;
    repeat (4) tick();
    chk("gs_ghr0", g_ghr, 4'h0);
    chk("gs_miss_nt", g_miss, 4'd2);
    g_valid = 1'b0; g_bid = 4'd0;
    #1;
    chk("gs_alias_read", g_pred, 2'd3);
    chk("gs_alias_pt", g_pt, 1'b1);
    g_bid = 4'd3;
    #1;
    chk("gs_b3_ghr0", g_pred, 2'd1);
`ifdef BP_STATS_EN
    chk("gs_look", g_look, 4'd7);
`else
    chk("gs_look", g_look, 4'd0);
`endif

    // Mispredict every cycle: 4-bit counter saturates at 15.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      g_valid = 1'b1;
      g_bid   = i[3:0];
      #1;
      g_out = ~g_pt;
      tick();
      chk("sat_miss", g_miss, (i > 15) ? 15 : i);
    end
    g_valid = 1'b0;
`ifdef BP_STATS_EN
    chk("sat_look", g_look, 4'd15);
`else
    chk("sat_look", g_look, 4'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
